calc1_port_driver: RTL and testbench
====================================

CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of buffered commands; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: WAIT-state watchdog limit; used only under CALC1_DRV_TIMEOUT_EN.
REQ-003 SHALL have port c_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, in_cmd in 4, in_op1 in 32, in_op2 in 32: upstream command handshake.
REQ-006 SHALL have ports req_cmd_out out 4, req_data_out out 32: registered outputs driving one calc1 port (reqN_cmd_in / reqN_data_in).
REQ-007 SHALL have ports calc_resp_in in 2, calc_data_in in 32: sampled from that calc1 port's out_respN / out_dataN.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_resp out 2, rsp_data out 32, rsp_cmd out 4: downstream result handshake; rsp_cmd echoes the issued command.
REQ-009 SHALL have port busy out 1: high whenever state is not IDLE or FIFO is non-empty.

Function
REQ-010 SHALL push {in_cmd, in_op1, in_op2} into the FIFO on each edge with in_valid && in_ready.
REQ-011 SHALL drive in_ready = !full, combinationally from the FIFO count; a push is refused when full even if a pop occurs on the same edge.
REQ-012 SHALL implement FSM states IDLE, SEND1, SEND2, WAIT, HOLD.
REQ-013 IDLE -> SEND1 when the FIFO is non-empty; the FIFO pops on this edge.
REQ-014 SEND1 SHALL drive req_cmd_out = cmd and req_data_out = op1 for exactly one cycle, then go to SEND2.
REQ-015 SEND2 SHALL drive req_cmd_out = 0 and req_data_out = op2 for exactly one cycle, then go to WAIT.
REQ-016 In IDLE, WAIT and HOLD, req_cmd_out and req_data_out SHALL be 0.
REQ-017 With an empty FIFO and IDLE state, a command accepted on edge E SHALL appear on the req ports from edge E+2; op2 SHALL appear from edge E+3.
REQ-018 In WAIT, the first edge with calc_resp_in != 0 SHALL capture rsp_resp = calc_resp_in, rsp_data = calc_data_in and rsp_cmd, set rsp_valid, and go to HOLD.
REQ-019 HOLD SHALL keep rsp_* stable while rsp_ready = 0; on an edge with rsp_valid && rsp_ready it SHALL clear rsp_valid and return to IDLE.
REQ-020 Only one command SHALL be outstanding; the next SEND1 occurs no earlier than the edge after the response handshake.
REQ-021 calc_resp_in != 0 in any state other than WAIT SHALL be ignored.
REQ-022 Command codes SHALL pass through unchecked; invalid codes return whatever calc1 reports (resp 2).
REQ-023 Pushes SHALL continue during SEND/WAIT/HOLD until full; FIFO order SHALL be preserved; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 Reset SHALL force IDLE, empty the FIFO, and zero rsp_valid, rsp_resp, rsp_data, rsp_cmd, req_cmd_out, req_data_out and the watchdog.
REQ-025 Reset asserted in any state, including mid-SEND or WAIT, SHALL abandon the in-flight command with no response; the paired calc1 is reset concurrently.
REQ-026 in_ready SHALL be high on the first edge after reset deasserts.

Configuration
REQ-027 With CALC1_DRV_TIMEOUT_EN defined, a watchdog SHALL count WAIT cycles; reaching TIMEOUT_CYCLES without a response SHALL capture rsp_resp = 3 and rsp_data = 0 and go to HOLD.
REQ-028 With CALC1_DRV_TIMEOUT_EN defined, a late calc1 response after a timeout is ignored only if it arrives outside WAIT; the bench SHALL not rely on late responses.
REQ-029 Without CALC1_DRV_TIMEOUT_EN, WAIT SHALL persist indefinitely, and no counter logic SHALL be synthesised.

Verification
REQ-030 cmd 1, op1 0x00000001, op2 0x1FFFFFFF -> req ports show (1,0x1), then (0,0x1FFFFFFF); rsp_resp 1, rsp_data 0x20000000, rsp_cmd 1.
REQ-031 cmd 1, op1 0xFFFFFFFF, op2 0x00000001 -> rsp_resp 2, rsp_data 0.
REQ-032 Push 5 commands back-to-back with rsp_ready = 0 -> in_ready drops after the FIFO fills (4 buffered plus 1 in flight); responses later drain in push order.
REQ-033 Hold rsp_ready low for 10 cycles after rsp_valid -> rsp_* stable, no new SEND1 issued; the next command issues on the edge after the handshake.
REQ-034 With CALC1_DRV_TIMEOUT_EN defined and calc_resp_in tied to 0 -> rsp_valid after 64 WAIT cycles with rsp_resp 3, rsp_data 0.
REQ-035 Assert reset for 1 cycle during WAIT with 2 commands queued -> IDLE, FIFO empty, all outputs 0, no rsp_valid; a new cmd 5 with op1 0x1, op2 0x1 then completes with rsp_data 0x2.

Source files
------------

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: buffers upstream commands in a small FIFO and drives them,
// one at a time, onto a single calc1 request port (cmd+op1, then op2), captures
// the calc1 response and offers it downstream on a valid/ready handshake.
// Optional WAIT-state watchdog is built only when CALC1_DRV_TIMEOUT_EN is defined.
module calc1_port_driver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    // upstream command handshake
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    // calc1 request port
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    // calc1 response port
    input  logic [1:0]  calc_resp_in,
    input  logic [31:0] calc_data_in,
    // downstream result handshake
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_cmd,
    output logic        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEND1 = 3'd1;
    localparam logic [2:0] SEND2 = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("calc1_port_driver: FIFO_DEPTH or TIMEOUT_CYCLES out of range");
    end

    logic [2:0]       state;
    logic [3:0]       fifo_cmd [FIFO_DEPTH];
    logic [31:0]      fifo_op1 [FIFO_DEPTH];
    logic [31:0]      fifo_op2 [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       cur_cmd;
    logic [31:0]      cur_op1;
    logic [31:0]      cur_op2;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             timeout_hit;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // Readiness depends only on the current count, so a same-edge pop never frees a slot.
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == IDLE) && !empty;
    assign busy     = (state != IDLE) || !empty;

`ifdef CALC1_DRV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt;

    // Watchdog counts edges spent in WAIT; cleared whenever WAIT is left.
    always_ff @(posedge c_clk) begin
        if (reset || state != WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th WAIT edge without a response.
    assign timeout_hit = (state == WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge c_clk) begin
        if (push) begin
            fifo_cmd[wr_ptr] <= in_cmd;
            fifo_op1[wr_ptr] <= in_op1;
            fifo_op2[wr_ptr] <= in_op2;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge c_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Command FSM; req outputs are registered so they lag the state by one edge.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state        <= IDLE;
            cur_cmd      <= '0;
            cur_op1      <= '0;
            cur_op2      <= '0;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            rsp_valid    <= 1'b0;
            rsp_resp     <= '0;
            rsp_data     <= '0;
            rsp_cmd      <= '0;
        end else begin
            req_cmd_out  <= '0;
            req_data_out <= '0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_cmd <= fifo_cmd[rd_ptr];
                        cur_op1 <= fifo_op1[rd_ptr];
                        cur_op2 <= fifo_op2[rd_ptr];
                        state   <= SEND1;
                    end
                end
                SEND1: begin
                    req_cmd_out  <= cur_cmd;
                    req_data_out <= cur_op1;
                    state        <= SEND2;
                end
                SEND2: begin
                    req_data_out <= cur_op2;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (calc_resp_in != 2'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_resp  <= calc_resp_in;
                        rsp_data  <= calc_data_in;
                        rsp_cmd   <= cur_cmd;
                        state     <= HOLD;
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_resp  <= 2'd3;
                        rsp_data  <= '0;
                        rsp_cmd   <= cur_cmd;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Testbench for calc1_port_driver: directed vectors with hand-computed results,
// a stand-in calc1 responder and a scoreboard monitor on the response handshake.
module tb_calc1_port_driver;
    logic        c_clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  calc_resp_in;
    logic [31:0] calc_data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_cmd;
    logic        busy;

    calc1_port_driver #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .req_cmd_out (req_cmd_out),
        .req_data_out(req_data_out),
        .calc_resp_in(calc_resp_in),
        .calc_data_in(calc_data_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_resp    (rsp_resp),
        .rsp_data    (rsp_data),
        .rsp_cmd     (rsp_cmd),
        .busy        (busy)
    );

    // One vector: command, operands, the response calc1 gives, and its latency
    // in cycles after op2 (negative: calc1 never answers).
    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
        int          delay;
    } vec_t;

    vec_t req_q[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic flush   = 1'b0;

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation time limit reached, expected finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Present a command from posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] r, input logic [31:0] d, input int dly);
        vec_t v;
        int   waited;
        v.cmd = c; v.op1 = a; v.op2 = b; v.resp = r; v.data = d; v.delay = dly;
        in_valid = 1'b1;
        in_cmd   = c;
        in_op1   = a;
        in_op2   = b;
        waited   = 0;
        @(negedge c_clk);
        while (!in_ready && waited < 200) begin
            @(negedge c_clk);
            waited++;
        end
        if (!in_ready) begin
            fail_now("send_accept", "in_ready never rose within 200 cycles");
        end else begin
            req_q.push_back(v);
            exp_q.push_back(v);
        end
        @(posedge c_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int waited;
        waited = 0;
        @(negedge c_clk);
        while ((exp_q.size() != 0 || busy) && waited < limit) begin
            @(negedge c_clk);
            waited++;
        end
        if (exp_q.size() != 0 || busy) fail_now("drain", "responses still pending at cycle limit");
        @(posedge c_clk);
        #1;
    endtask

    // Scoreboard monitor: every completed response handshake pops one expectation.
    initial begin
        vec_t e;
        forever begin
            @(negedge c_clk);
            if (!reset && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected", "response handshake with nothing outstanding");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_cmd", 32'(rsp_cmd), 32'(e.cmd));
                end
            end
        end
    end

    // Stand-in calc1: checks the two request phases, then answers after the delay.
    initial begin
        vec_t v;
        logic aborted;
        calc_resp_in = 2'd0;
        calc_data_in = 32'd0;
        @(negedge c_clk);
        while (reset) @(negedge c_clk);
        // A response while IDLE must be ignored.
        calc_resp_in = 2'd2;
        calc_data_in = 32'h0000_1234;
        repeat (3) @(negedge c_clk);
        calc_resp_in = 2'd0;
        calc_data_in = 32'd0;
        forever begin
            @(negedge c_clk);
            if (!reset && req_cmd_out != 4'd0) begin
                if (req_q.size() == 0) begin
                    fail_now("req_unexpected", "request issued with nothing queued");
                end else begin
                    v = req_q.pop_front();
                    check("req_phase1_cmd", 32'(req_cmd_out), 32'(v.cmd));
                    check("req_phase1_op1", req_data_out, v.op1);
                    // Driver sits in SEND2 for the next edge; this must not be captured.
                    calc_resp_in = 2'd3;
                    calc_data_in = 32'hBAD0_BAD0;
                    @(negedge c_clk);
                    calc_resp_in = 2'd0;
                    calc_data_in = 32'd0;
                    check("req_phase2_cmd", 32'(req_cmd_out), 32'd0);
                    check("req_phase2_op2", req_data_out, v.op2);
                    if (v.delay >= 0) begin
                        aborted = 1'b0;
                        for (int i = 0; i < v.delay; i++) begin
                            @(negedge c_clk);
                            if (flush) begin
                                aborted = 1'b1;
                                break;
                            end
                        end
                        if (!aborted) begin
                            calc_resp_in = v.resp;
                            calc_data_in = v.data;
                            @(negedge c_clk);
                            calc_resp_in = 2'd0;
                            calc_data_in = 32'd0;
                        end
                    end
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_req_cmd"}, 32'(req_cmd_out), 32'd0);
        check({tag, "_req_data"}, req_data_out, 32'd0);
        check({tag, "_rsp_resp"}, 32'(rsp_resp), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_cmd"}, 32'(rsp_cmd), 32'd0);
    endtask

    initial begin
        logic [1:0]  s_resp;
        logic [31:0] s_data;
        logic [3:0]  s_cmd;
        int          waited;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_cmd    = 4'd0;
        in_op1    = 32'd0;
        in_op2    = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge c_clk);
        #1;
        reset = 1'b0;

        // Reset state, and a stray response in IDLE is ignored.
        @(negedge c_clk);
        check_idle_outputs("reset");
        repeat (5) @(negedge c_clk);
        check("idle_spurious_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_spurious_busy", 32'(busy), 32'd0);
        @(posedge c_clk);
        #1;

        // Add with exact request latency: cmd on E+2, op2 on E+3.
        send(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 3);
        @(negedge c_clk);
        @(negedge c_clk);
        check("lat_e1_req_cmd", 32'(req_cmd_out), 32'd0);
        @(negedge c_clk);
        check("lat_e2_req_cmd", 32'(req_cmd_out), 32'd1);
        check("lat_e2_req_data", req_data_out, 32'h0000_0001);
        @(negedge c_clk);
        check("lat_e3_req_cmd", 32'(req_cmd_out), 32'd0);
        check("lat_e3_req_data", req_data_out, 32'h1FFF_FFFF);
        wait_drain(100);

        // Overflow, subtract, invalid code, shift right.
        send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 2);
        send(4'd2, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0002, 0);
        send(4'd3, 32'h0000_0011, 32'h0000_0022, 2'd2, 32'h0000_0000, 4);
        send(4'd6, 32'h0000_0080, 32'h0000_0004, 2'd1, 32'h0000_0008, 1);
        wait_drain(200);

        // Five back-to-back with downstream stalled: four buffered plus one in flight.
        rsp_ready = 1'b0;
        send(4'd1, 32'd10, 32'd20, 2'd1, 32'd30, 1);
        send(4'd2, 32'd100, 32'd1, 2'd1, 32'd99, 1);
        send(4'd5, 32'd3, 32'd2, 2'd1, 32'd12, 1);
        send(4'd6, 32'h0000_0100, 32'd8, 2'd1, 32'd1, 1);
        send(4'd2, 32'd1, 32'd2, 2'd2, 32'd0, 1);
        @(negedge c_clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        repeat (20) @(negedge c_clk);
        check("full_in_ready_held", 32'(in_ready), 32'd0);
        check("full_first_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge c_clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain(300);

        // Stall a response for 10 cycles with another command queued behind it.
        rsp_ready = 1'b0;
        send(4'd1, 32'd7, 32'd8, 2'd1, 32'd15, 2);
        send(4'd2, 32'd9, 32'd4, 2'd1, 32'd5, 1);
        waited = 0;
        @(negedge c_clk);
        while (!rsp_valid && waited < 50) begin
            @(negedge c_clk);
            waited++;
        end
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        s_resp = rsp_resp;
        s_data = rsp_data;
        s_cmd  = rsp_cmd;
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            check("hold_stable", {rsp_valid, rsp_resp, rsp_cmd, 1'b0, req_cmd_out, 20'd0},
                  {1'b1, s_resp, s_cmd, 1'b0, 4'd0, 20'd0});
            check("hold_data_stable", rsp_data, s_data);
        end
        @(posedge c_clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge c_clk);
        @(negedge c_clk);
        check("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge c_clk);
        check("after_hs_send1_req_cmd", 32'(req_cmd_out), 32'd0);
        @(negedge c_clk);
        check("after_hs_issue_req_cmd", 32'(req_cmd_out), 32'd2);
        wait_drain(100);

        // Reset during WAIT with two commands queued abandons everything.
        send(4'd1, 32'd1, 32'd2, 2'd1, 32'd3, 40);
        send(4'd1, 32'd4, 32'd5, 2'd1, 32'd9, 0);
        send(4'd2, 32'd6, 32'd1, 2'd1, 32'd5, 0);
        repeat (8) @(negedge c_clk);
        flush = 1'b1;
        @(negedge c_clk);
        @(negedge c_clk);
        exp_q.delete();
        req_q.delete();
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        @(negedge c_clk);
        check_idle_outputs("midwait_reset");
        for (int i = 0; i < 30; i++) begin
            @(negedge c_clk);
            check("post_reset_quiet", {27'd0, rsp_valid, req_cmd_out}, 32'd0);
        end
        @(posedge c_clk);
        #1;
        send(4'd5, 32'h0000_0001, 32'h0000_0001, 2'd1, 32'h0000_0002, 2);
        wait_drain(100);

`ifdef CALC1_DRV_TIMEOUT_EN
        // calc1 silent: watchdog produces resp 3, data 0.
        send(4'd1, 32'd3, 32'd4, 2'd3, 32'd0, -1);
        wait_drain(300);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
